// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO that feeds a UART transmitter over tx_start/tx_busy/tx_done.
// Optional: define UART_TX_FIFO_DROP_CNT_EN to add drop_cnt, a saturating count of dropped writes.
//
// state  | meaning
// IDLE   | ready to launch the head byte as soon as the FIFO is non-empty and tx_busy=0
// WAIT   | frame launched, waiting for the transmitter's tx_done pulse
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          ovf_clr,
   input  logic          tx_busy,
   input  logic          tx_done,
   output logic          tx_start,
   output logic [7:0]    tx_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
`ifdef UART_TX_FIFO_DROP_CNT_EN
   output logic [7:0]    drop_cnt,
`endif
   output logic          overflow
);

   localparam logic [0:0]  S_IDLE   = 1'b0;
   localparam logic [0:0]  S_WAIT   = 1'b1;
   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic [0:0]    r_state;
   logic          r_tx_start;
   logic [7:0]    r_tx_data;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_drop;
   logic          w_pop;

   // Flags come from the registered count only, so a write never sees its own effect.
   assign w_full  = (r_count == LP_DEPTH);
   assign w_empty = (r_count == '0);
   assign w_push  = wr_en & ~w_full;
   assign w_drop  = wr_en & w_full;
   assign w_pop   = (r_state == S_IDLE) & ~w_empty & ~tx_busy;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // A dropped write in the same cycle as ovf_clr keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
      end
   end

`ifdef UART_TX_FIFO_DROP_CNT_EN
   logic [7:0] r_drop_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop_cnt <= '0;
      end else if (ovf_clr) begin
         r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
      end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
         r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

   // tx_busy is ignored in WAIT: the transmitter only raises it a cycle after tx_start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_tx_start <= 1'b1;
                  r_tx_data  <= r_mem[r_rd_ptr];
                  r_state    <= S_WAIT;
               end else begin
                  r_tx_start <= 1'b0;
               end
            end
            S_WAIT: begin
               r_tx_start <= 1'b0;
               if (tx_done) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_tx_start <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;
   assign full     = w_full;
   assign empty    = w_empty;
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule
